// File: rtl/movimenta_asteroides.sv
// Asteroid-movement responder: walks the asteroid table once per start pulse,
// moves every active entry one cell along its direction (toroidal grid) and pulses done.
module movimenta_asteroides #(
  parameter  int N_AST   = 16,
  parameter  int COORD_W = 4,
  localparam int AW      = $clog2(N_AST),
  localparam int DW      = 4 + 2 * COORD_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sinal_movimenta_asteroides,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          fim_move_asteroides,
  output logic          ocupado,
  output logic [2:0]    db_estado
);

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] LE      = 3'd1;
  localparam logic [2:0] RECEBE  = 3'd2;
  localparam logic [2:0] CALCULA = 3'd3;
  localparam logic [2:0] ESCREVE = 3'd4;
  localparam logic [2:0] PROXIMO = 3'd5;
  localparam logic [2:0] FIM     = 3'd6;

  localparam logic [AW-1:0] ULTIMO = AW'(N_AST - 1);

  logic [2:0]    r_estado;
  logic [2:0]    w_estado_next;
  logic [AW-1:0] r_idx;
  logic [DW-1:0] r_ent;
  logic [DW-1:0] r_wdata;

  logic                 w_ativo;
  logic [2:0]           w_dir;
  logic [COORD_W-1:0]   w_x;
  logic [COORD_W-1:0]   w_y;
  logic [COORD_W-1:0]   w_dx;
  logic [COORD_W-1:0]   w_dy;
  logic [COORD_W-1:0]   w_x_novo;
  logic [COORD_W-1:0]   w_y_novo;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= OCIOSO;
    else       r_estado <= w_estado_next;
  end

  // Next-state logic
  always_comb begin
    w_estado_next = OCIOSO;
    case (r_estado)
      OCIOSO:  w_estado_next = sinal_movimenta_asteroides ? LE : OCIOSO;
      LE:      w_estado_next = RECEBE;
      RECEBE:  w_estado_next = mem_rdata[DW-1] ? CALCULA : PROXIMO;
      CALCULA: w_estado_next = ESCREVE;
      ESCREVE: w_estado_next = PROXIMO;
      PROXIMO: w_estado_next = (r_idx == ULTIMO) ? FIM : LE;
      FIM:     w_estado_next = OCIOSO;
      default: w_estado_next = OCIOSO;
    endcase
  end

  // Moore outputs
  always_comb begin
    mem_we              = (r_estado == ESCREVE);
    fim_move_asteroides = (r_estado == FIM);
    ocupado             = (r_estado != OCIOSO);
    db_estado           = r_estado;
    mem_addr            = r_idx;
    mem_wdata           = r_wdata;
  end

  assign {w_ativo, w_dir, w_x, w_y} = r_ent;

  // Step of -1 is all ones, so a plain modulo add handles wrap on both edges.
  always_comb begin
    w_dx = '0;
    w_dy = '0;
    case (w_dir)
      3'd0: begin w_dx = '0;                w_dy = '1;                end
      3'd1: begin w_dx = COORD_W'(1);       w_dy = '1;                end
      3'd2: begin w_dx = COORD_W'(1);       w_dy = '0;                end
      3'd3: begin w_dx = COORD_W'(1);       w_dy = COORD_W'(1);       end
      3'd4: begin w_dx = '0;                w_dy = COORD_W'(1);       end
      3'd5: begin w_dx = '1;                w_dy = COORD_W'(1);       end
      3'd6: begin w_dx = '1;                w_dy = '0;                end
      default: begin w_dx = '1;             w_dy = '1;                end
    endcase
  end

  assign w_x_novo = w_x + w_dx;
  assign w_y_novo = w_y + w_dy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx   <= '0;
      r_ent   <= '0;
      r_wdata <= '0;
    end else begin
      case (r_estado)
        OCIOSO:  r_idx <= '0;
        RECEBE:  r_ent <= mem_rdata;
        CALCULA: r_wdata <= {1'b1, w_dir, w_x_novo, w_y_novo};
        PROXIMO: if (r_idx != ULTIMO) r_idx <= r_idx + AW'(1);
        default: ;
      endcase
    end
  end

  logic w_unused;
  assign w_unused = w_ativo;

endmodule
